// File: rtl/nec_prefetch_pkg.sv
// Shared types for the instruction prefetch queue and the decoder that reads it.
// Holds the queue depth, the prefetch FSM state encoding, the bus request
// payload and the segment:offset to physical address helper.
package nec_prefetch_pkg;

    // Queue depth; the decoder indexes the queue with pc[2:0].
    localparam int unsigned IPQ_SIZE  = 8;
    localparam int unsigned IPQ_IDX_W = 3;
    localparam int unsigned IPQ_LEN_W = 4;
    localparam int unsigned OFS_W     = 16;
    localparam int unsigned SEG_W     = 16;
    localparam int unsigned ADDR_W    = 20;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,
        PF_WAIT    = 2'd1,
        PF_DISCARD = 2'd2
    } prefetch_state_e;

    // Outstanding fetch as presented on the bus.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              word;
    } pf_req_t;

    // Physical address of seg:ofs, wrapping at 1 MiB.
    function automatic logic [ADDR_W-1:0] pf_phys_addr(
        input logic [SEG_W-1:0] seg,
        input logic [OFS_W-1:0] ofs
    );
        return {seg, 4'b0000} + {4'b0000, ofs};
    endfunction

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch queue feeding the instruction decoder.
// Fetches code bytes at CS:fetch_ofs into an 8-byte circular buffer indexed by
// address bits [2:0]; the decoder consumes by advancing decode_pc and flushes
// the queue with set_pc.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   ce_1, ce_2          phase clock enables; state only moves when either is high
//   cs                  current code segment
//   decode_pc           next byte the decoder will consume
//   set_pc, new_pc      flush and restart fetching at new_pc
//   ipq[8], ipq_len     queue bytes (address A in ipq[A[2:0]]) and valid count
//   pf_req/addr/word    fetch request, held until pf_ready
//   pf_ready, pf_data   fetch completion; odd-address byte on pf_data[15:8]
//
// Optional build macro NEC_PREFETCH_PERF_EN adds perf_starve and perf_flush
// saturating event counters as extra outputs.
module nec_prefetch
    import nec_prefetch_pkg::*;
#(
    parameter int unsigned WORD_FETCH = 1,
    parameter int unsigned QUEUE_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce_1,
    input  logic                 ce_2,
    input  logic [SEG_W-1:0]     cs,
    input  logic [OFS_W-1:0]     decode_pc,
    input  logic                 set_pc,
    input  logic [OFS_W-1:0]     new_pc,
    output logic [7:0]           ipq [IPQ_SIZE],
    output logic [IPQ_LEN_W-1:0] ipq_len,
    output logic                 pf_req,
    output logic [ADDR_W-1:0]    pf_addr,
    output logic                 pf_word,
    input  logic                 pf_ready,
    input  logic [15:0]          pf_data
`ifdef NEC_PREFETCH_PERF_EN
    ,
    output logic [15:0]          perf_starve,
    output logic [15:0]          perf_flush
`endif
);

    // The decoder addresses the queue with pc[2:0], so no other depth works.
    if (QUEUE_SIZE != IPQ_SIZE) begin : g_bad_queue_size
        $error("nec_prefetch: QUEUE_SIZE must be 8");
    end

    localparam bit WORD_EN = (WORD_FETCH != 0);

    logic                 en_c;
    prefetch_state_e      state_q, state_d;
    logic [OFS_W-1:0]     fetch_ofs_q, fetch_ofs_d;
    logic                 primed_q, primed_d;
    logic [7:0]           ipq_q [IPQ_SIZE];
    logic [7:0]           ipq_d [IPQ_SIZE];
    logic                 pf_req_q, pf_req_d;
    pf_req_t              req_q, req_d;
    logic [IPQ_LEN_W-1:0] ipq_len_c;
    logic [IPQ_LEN_W-1:0] free_c;
    logic [IPQ_IDX_W-1:0] wr_idx_c;
    logic [IPQ_IDX_W-1:0] wr_idx_hi_c;

    assign en_c = ce_1 | ce_2;

    // Bytes between the decoder and the fetch pointer; never exceeds 8.
    assign ipq_len_c   = primed_q ? IPQ_LEN_W'(fetch_ofs_q - decode_pc) : '0;
    assign free_c      = IPQ_LEN_W'(IPQ_SIZE) - ipq_len_c;
    assign wr_idx_c    = fetch_ofs_q[IPQ_IDX_W-1:0];
    assign wr_idx_hi_c = wr_idx_c + IPQ_IDX_W'(1);

    // Next-state, fetch issue and queue write.
    always_comb begin
        state_d     = state_q;
        fetch_ofs_d = fetch_ofs_q;
        primed_d    = primed_q;
        ipq_d       = ipq_q;
        pf_req_d    = pf_req_q;
        req_d       = req_q;

        if (en_c) begin
            if (set_pc) begin
                fetch_ofs_d = new_pc;
                primed_d    = 1'b1;
            end

            unique case (state_q)
                PF_IDLE: begin
                    if (!set_pc && primed_q) begin
                        // Even offsets on a 16-bit bus wait for a whole word of space.
                        if (WORD_EN && !fetch_ofs_q[0] && (free_c >= IPQ_LEN_W'(2))) begin
                            pf_req_d   = 1'b1;
                            req_d.addr = pf_phys_addr(cs, fetch_ofs_q);
                            req_d.word = 1'b1;
                            state_d    = PF_WAIT;
                        end else if ((free_c >= IPQ_LEN_W'(1)) &&
                                     (fetch_ofs_q[0] || !WORD_EN)) begin
                            pf_req_d   = 1'b1;
                            req_d.addr = pf_phys_addr(cs, fetch_ofs_q);
                            req_d.word = 1'b0;
                            state_d    = PF_WAIT;
                        end
                    end
                end

                PF_WAIT: begin
                    if (pf_ready) begin
                        // A flush in the same cycle as the ack drops the data.
                        if (!set_pc) begin
                            if (req_q.word) begin
                                ipq_d[wr_idx_c]    = pf_data[7:0];
                                ipq_d[wr_idx_hi_c] = pf_data[15:8];
                                fetch_ofs_d        = fetch_ofs_q + OFS_W'(2);
                            end else begin
                                ipq_d[wr_idx_c] = fetch_ofs_q[0] ? pf_data[15:8] : pf_data[7:0];
                                fetch_ofs_d     = fetch_ofs_q + OFS_W'(1);
                            end
                        end
                        pf_req_d = 1'b0;
                        state_d  = PF_IDLE;
                    end else if (set_pc) begin
                        // The bus cycle cannot be aborted; wait it out and drop it.
                        state_d = PF_DISCARD;
                    end
                end

                PF_DISCARD: begin
                    if (pf_ready) begin
                        pf_req_d = 1'b0;
                        state_d  = PF_IDLE;
                    end
                end

                default: begin
                    pf_req_d = 1'b0;
                    state_d  = PF_IDLE;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PF_IDLE;
            fetch_ofs_q <= '0;
            primed_q    <= 1'b0;
            pf_req_q    <= 1'b0;
            req_q       <= '0;
            for (int i = 0; i < IPQ_SIZE; i++) begin
                ipq_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_ofs_q <= fetch_ofs_d;
            primed_q    <= primed_d;
            pf_req_q    <= pf_req_d;
            req_q       <= req_d;
            for (int i = 0; i < IPQ_SIZE; i++) begin
                ipq_q[i] <= ipq_d[i];
            end
        end
    end

    assign ipq     = ipq_q;
    assign ipq_len = ipq_len_c;
    assign pf_req  = pf_req_q;
    assign pf_addr = req_q.addr;
    assign pf_word = req_q.word;

`ifdef NEC_PREFETCH_PERF_EN
    logic [15:0] starve_q, starve_d;
    logic [15:0] flush_q, flush_d;

    // Saturating counters for decoder starvation and flushes.
    always_comb begin
        starve_d = starve_q;
        flush_d  = flush_q;
        if (en_c) begin
            if (primed_q && (ipq_len_c == '0) && (starve_q != 16'hFFFF)) begin
                starve_d = starve_q + 16'd1;
            end
            if (set_pc && (flush_q != 16'hFFFF)) begin
                flush_d = flush_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
            flush_q  <= '0;
        end else begin
            starve_q <= starve_d;
            flush_q  <= flush_d;
        end
    end

    assign perf_starve = starve_q;
    assign perf_flush  = flush_q;
`endif

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed bench for nec_prefetch: a 16-bit bus instance and an 8-bit bus
// instance, table-driven fill/consume vectors plus hand sequences for flushes,
// clock-enable gating and address wrap.
module tb_nec_prefetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_1, ce_2;
    logic [15:0] cs;

    logic [15:0] decode_pc, new_pc, pf_data;
    logic        set_pc, pf_ready;
    logic [7:0]  ipq [8];
    logic [3:0]  ipq_len;
    logic        pf_req, pf_word;
    logic [19:0] pf_addr;

    logic [15:0] b_decode_pc, b_new_pc, b_pf_data;
    logic        b_set_pc, b_pf_ready;
    logic [7:0]  b_ipq [8];
    logic [3:0]  b_ipq_len;
    logic        b_pf_req, b_pf_word;
    logic [19:0] b_pf_addr;

`ifdef NEC_PREFETCH_PERF_EN
    logic [15:0] perf_starve, perf_flush, b_perf_starve, b_perf_flush;
`endif

    int total = 0;
    int bad   = 0;

    nec_prefetch #(.WORD_FETCH(1), .QUEUE_SIZE(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .ce_1(ce_1), .ce_2(ce_2), .cs(cs),
        .decode_pc(decode_pc), .set_pc(set_pc), .new_pc(new_pc),
        .ipq(ipq), .ipq_len(ipq_len), .pf_req(pf_req), .pf_addr(pf_addr),
        .pf_word(pf_word), .pf_ready(pf_ready), .pf_data(pf_data)
`ifdef NEC_PREFETCH_PERF_EN
        , .perf_starve(perf_starve), .perf_flush(perf_flush)
`endif
    );

    nec_prefetch #(.WORD_FETCH(0), .QUEUE_SIZE(8)) u_byte (
        .clk(clk), .reset_n(reset_n), .ce_1(ce_1), .ce_2(ce_2), .cs(cs),
        .decode_pc(b_decode_pc), .set_pc(b_set_pc), .new_pc(b_new_pc),
        .ipq(b_ipq), .ipq_len(b_ipq_len), .pf_req(b_pf_req), .pf_addr(b_pf_addr),
        .pf_word(b_pf_word), .pf_ready(b_pf_ready), .pf_data(b_pf_data)
`ifdef NEC_PREFETCH_PERF_EN
        , .perf_starve(b_perf_starve), .perf_flush(b_perf_flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dpc;
        bit          req;
        logic [19:0] addr;
        bit          word;
        logic [15:0] data;
        logic [3:0]  len;
        int          idx;
        logic [7:0]  val;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a request on either instance.
    task automatic wait_req(input bit bdut, input string name);
        int n = 0;
        while (!(bdut ? b_pf_req : pf_req) && n < 16) begin
            tick();
            n++;
        end
        chk({name, "_req"}, 32'(bdut ? b_pf_req : pf_req), 32'd1);
    endtask

    task automatic ack(input bit bdut, input logic [15:0] d);
        if (bdut) begin
            b_pf_ready = 1'b1;
            b_pf_data  = d;
        end else begin
            pf_ready = 1'b1;
            pf_data  = d;
        end
        tick();
        b_pf_ready = 1'b0;
        pf_ready   = 1'b0;
    endtask

    task automatic setpc(input logic [15:0] pc);
        set_pc    = 1'b1;
        new_pc    = pc;
        decode_pc = pc;
        tick();
        set_pc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [10];
        logic [7:0]  fin [8];
        logic [15:0] bd;
        logic [7:0]  bexp;

        tbl[0] = '{16'h0103, 1'b1, 20'h10103, 1'b0, 16'h3322, 4'd1, 3, 8'h33};
        tbl[1] = '{16'h0103, 1'b1, 20'h10104, 1'b1, 16'h5544, 4'd3, 5, 8'h55};
        tbl[2] = '{16'h0103, 1'b1, 20'h10106, 1'b1, 16'h7766, 4'd5, 6, 8'h66};
        tbl[3] = '{16'h0103, 1'b1, 20'h10108, 1'b1, 16'h9988, 4'd7, 0, 8'h88};
        tbl[4] = '{16'h0103, 1'b0, 20'h0,     1'b0, 16'h0,    4'd7, -1, 8'h0};
        tbl[5] = '{16'h0104, 1'b1, 20'h1010A, 1'b1, 16'hBBAA, 4'd8, 3, 8'hBB};
        tbl[6] = '{16'h0104, 1'b0, 20'h0,     1'b0, 16'h0,    4'd8, -1, 8'h0};
        tbl[7] = '{16'h0105, 1'b0, 20'h0,     1'b0, 16'h0,    4'd7, -1, 8'h0};
        tbl[8] = '{16'h0106, 1'b1, 20'h1010C, 1'b1, 16'hDDCC, 4'd8, 4, 8'hCC};
        tbl[9] = '{16'h010E, 1'b1, 20'h1010E, 1'b1, 16'hFFEE, 4'd2, 7, 8'hFF};
        fin = '{8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

        reset_n = 1'b0;
        ce_1 = 1'b1; ce_2 = 1'b0; cs = 16'h0;
        decode_pc = 16'h0; new_pc = 16'h0; set_pc = 1'b0; pf_ready = 1'b0; pf_data = 16'h0;
        b_decode_pc = 16'h0; b_new_pc = 16'h0; b_set_pc = 1'b0; b_pf_ready = 1'b0; b_pf_data = 16'h0;
        tick();
        tick();
        chk("rst_req", 32'(pf_req), 32'd0);
        chk("rst_addr", 32'(pf_addr), 32'h0);
        chk("rst_word", 32'(pf_word), 32'd0);
        chk("rst_len", 32'(ipq_len), 32'd0);
        chk("rst_ipq5", 32'(ipq[5]), 32'h0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("unprimed_req", 32'(pf_req), 32'd0);
        chk("unprimed_b_req", 32'(b_pf_req), 32'd0);

        // Reset vector fetch.
        cs = 16'hFFFF;
        setpc(16'h0000);
        wait_req(1'b0, "boot");
        chk("boot_addr", 32'(pf_addr), 32'hFFFF0);
        chk("boot_word", 32'(pf_word), 32'd1);
        ack(1'b0, 16'hBBAA);
        chk("boot_ipq0", 32'(ipq[0]), 32'hAA);
        chk("boot_ipq1", 32'(ipq[1]), 32'hBB);
        chk("boot_len", 32'(ipq_len), 32'd2);

        // Odd start, fill to capacity, then consume-driven refills.
        cs = 16'h1000;
        setpc(16'h0103);
        for (int i = 0; i < 10; i++) begin
            decode_pc = tbl[i].dpc;
            tick();
            chk($sformatf("v%0d_req", i), 32'(pf_req), 32'(tbl[i].req));
            if (tbl[i].req) begin
                chk($sformatf("v%0d_addr", i), 32'(pf_addr), 32'(tbl[i].addr));
                chk($sformatf("v%0d_word", i), 32'(pf_word), 32'(tbl[i].word));
                ack(1'b0, tbl[i].data);
            end
            chk($sformatf("v%0d_len", i), 32'(ipq_len), 32'(tbl[i].len));
            if (tbl[i].idx >= 0)
                chk($sformatf("v%0d_ipq", i), 32'(ipq[tbl[i].idx]), 32'(tbl[i].val));
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("fill_ipq%0d", i), 32'(ipq[i]), 32'(fin[i]));

        // Flush during WAIT, plus a second flush while discarding.
        tick();
        chk("fl_req", 32'(pf_req), 32'd1);
        chk("fl_addr", 32'(pf_addr), 32'h10110);
        set_pc = 1'b1; new_pc = 16'h0400; decode_pc = 16'h0400;
        tick();
        set_pc = 1'b0;
        chk("fl_hold_req", 32'(pf_req), 32'd1);
        chk("fl_hold_addr", 32'(pf_addr), 32'h10110);
        chk("fl_len", 32'(ipq_len), 32'd0);
        tick();
        chk("fl_hold2_req", 32'(pf_req), 32'd1);
        set_pc = 1'b1; new_pc = 16'h0420; decode_pc = 16'h0420;
        tick();
        set_pc = 1'b0;
        ack(1'b0, 16'h1234);
        chk("fl_drop_req", 32'(pf_req), 32'd0);
        chk("fl_drop_ipq0", 32'(ipq[0]), 32'h88);
        chk("fl_drop_ipq1", 32'(ipq[1]), 32'h99);
        chk("fl_drop_len", 32'(ipq_len), 32'd0);
        wait_req(1'b0, "fl_next");
        chk("fl_next_addr", 32'(pf_addr), 32'h10420);
        chk("fl_next_word", 32'(pf_word), 32'd1);
        ack(1'b0, 16'h2211);
        chk("fl_next_ipq0", 32'(ipq[0]), 32'h11);
        chk("fl_next_len", 32'(ipq_len), 32'd2);

        // Flush coincident with the ack.
        tick();
        chk("co_addr", 32'(pf_addr), 32'h10422);
        set_pc = 1'b1; new_pc = 16'h0500; decode_pc = 16'h0500;
        pf_ready = 1'b1; pf_data = 16'h5678;
        tick();
        set_pc = 1'b0; pf_ready = 1'b0;
        chk("co_req", 32'(pf_req), 32'd0);
        chk("co_len", 32'(ipq_len), 32'd0);
        chk("co_ipq2", 32'(ipq[2]), 32'hAA);
        wait_req(1'b0, "co_next");
        chk("co_next_addr", 32'(pf_addr), 32'h10500);
        ack(1'b0, 16'h4433);
        chk("co_next_ipq0", 32'(ipq[0]), 32'h33);

        // Clock enables low: nothing moves, not even a flush.
        ce_1 = 1'b0; ce_2 = 1'b0;
        set_pc = 1'b1; new_pc = 16'h0700;
        tick(); tick();
        set_pc = 1'b0;
        chk("ce_req", 32'(pf_req), 32'd0);
        chk("ce_len", 32'(ipq_len), 32'd2);
        ce_2 = 1'b1;
        wait_req(1'b0, "ce2");
        chk("ce2_addr", 32'(pf_addr), 32'h10502);
        ack(1'b0, 16'h6655);
        chk("ce2_len", 32'(ipq_len), 32'd4);
        ce_1 = 1'b1; ce_2 = 1'b0;

        // Offset wrap at 0xFFFF and physical wrap at 1 MiB.
        cs = 16'hF000;
        setpc(16'hFFFE);
        wait_req(1'b0, "wr");
        chk("wr_addr", 32'(pf_addr), 32'hFFFFE);
        chk("wr_word", 32'(pf_word), 32'd1);
        ack(1'b0, 16'h4433);
        chk("wr_ipq6", 32'(ipq[6]), 32'h33);
        chk("wr_ipq7", 32'(ipq[7]), 32'h44);
        chk("wr_len", 32'(ipq_len), 32'd2);
        wait_req(1'b0, "wr2");
        chk("wr2_addr", 32'(pf_addr), 32'hF0000);
        chk("wr2_len_wait", 32'(ipq_len), 32'd2);
        ack(1'b0, 16'h6655);
        chk("wr2_len", 32'(ipq_len), 32'd4);
        chk("wr2_ipq0", 32'(ipq[0]), 32'h55);
        cs = 16'hFFFF;
        setpc(16'h0012);
        wait_req(1'b0, "pw");
        chk("pw_addr", 32'(pf_addr), 32'h00002);
        ack(1'b0, 16'h7788);
        chk("pw_len", 32'(ipq_len), 32'd2);

        // 8-bit bus instance: byte fetches only, lane chosen by address bit 0.
        cs = 16'h2000;
        b_set_pc = 1'b1; b_new_pc = 16'h0010; b_decode_pc = 16'h0010;
        tick();
        b_set_pc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_req(1'b1, $sformatf("b%0d", i));
            chk($sformatf("b%0d_addr", i), 32'(b_pf_addr), 32'h20010 + 32'(i));
            chk($sformatf("b%0d_word", i), 32'(b_pf_word), 32'd0);
            bd   = {8'(8'hB0 + i), 8'(8'hA0 + i)};
            bexp = (i % 2 == 1) ? 8'(8'hB0 + i) : 8'(8'hA0 + i);
            ack(1'b1, bd);
            chk($sformatf("b%0d_ipq", i), 32'(b_ipq[i]), 32'(bexp));
            chk($sformatf("b%0d_len", i), 32'(b_ipq_len), 32'(i + 1));
        end
        tick(); tick();
        chk("b_full_req", 32'(b_pf_req), 32'd0);
        chk("b_full_len", 32'(b_ipq_len), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
